// File: rtl/wash_seq_pkg.sv
// Shared types and the fixed wash-program table for the wash program sequencer.
package wash_seq_pkg;

  localparam int unsigned DUR_W = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_WASH,
    S_POST_WASH,
    S_SPIN
  } state_e;

  typedef enum logic [1:0] {
    PROG_QUICK  = 2'd0,
    PROG_NORMAL = 2'd1,
    PROG_HEAVY  = 2'd2,
    PROG_RSVD   = 2'd3
  } prog_e;

  typedef struct packed {
    logic [DUR_W-1:0] wash_ticks;
    logic [DUR_W-1:0] spin_ticks;
    logic [1:0]       passes;
  } prog_cfg_t;

  function automatic prog_cfg_t prog_cfg(input prog_e p);
    prog_cfg_t c;
    case (p)
      PROG_QUICK: c = '{wash_ticks: 8'd20, spin_ticks: 8'd10, passes: 2'd1};
      PROG_HEAVY: c = '{wash_ticks: 8'd60, spin_ticks: 8'd30, passes: 2'd3};
      default:    c = '{wash_ticks: 8'd40, spin_ticks: 8'd20, passes: 2'd2};
    endcase
    return c;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Prescaled, saturating phase timer; counts only while run_i is high.
module phase_timer #(
  parameter int unsigned TICK_DIV = 1000,
  parameter int unsigned TW       = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          run_i,
  input  logic          clear_i,
  input  logic [TW-1:0] target_i,
  output logic          expired_o
);

  localparam int unsigned PW = 16;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] presc_q, presc_d, presc_base;
  logic [TW-1:0] tick_q, tick_d, tick_base;

  // Clear restarts the count so that the entry cycle itself is cycle 0.
  always_comb begin
    presc_base = clear_i ? '0 : presc_q;
    tick_base  = clear_i ? '0 : tick_q;
    presc_d    = presc_base;
    tick_d     = tick_base;
    if (run_i) begin
      if (presc_base == PRESC_LAST) begin
        presc_d = '0;
        if (tick_base < target_i) begin
          tick_d = tick_base + 1'b1;
        end
      end else begin
        presc_d = presc_base + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc_q <= '0;
      tick_q  <= '0;
    end else begin
      presc_q <= presc_d;
      tick_q  <= tick_d;
    end
  end

  assign expired_o = (tick_q == target_i);

endmodule

// File: rtl/wash_program_sequencer.sv
// Program/timing controller driving the washer's cycleTO, spinTO and againwash inputs.
module wash_program_sequencer
  import wash_seq_pkg::*;
#(
  parameter int unsigned TICK_DIV = 1000,
  parameter int unsigned TW       = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] prog_sel,
  input  logic       prog_load,
  input  logic       water_wash,
  input  logic       motor_on,
  input  logic       drain_val_on,
  input  logic       done,
  output logic       cycleTO,
  output logic       spinTO,
  output logic       againwash,
  output logic       busy,
  output logic [1:0] pass_idx,
  output logic       prog_err
);

  state_e    state_q, state_d;
  prog_e     prog_q, prog_d;
  logic [1:0] pass_q, pass_d;
  logic      prog_err_q, prog_err_d;

  prog_cfg_t     cfg;
  logic          spin_phase;
  logic          tmr_run, tmr_clear, tmr_expired;
  logic [TW-1:0] tmr_target;

  assign cfg        = prog_cfg(prog_q);
  assign spin_phase = motor_on & ~water_wash & ~drain_val_on;

  always_comb begin
    state_d    = state_q;
    prog_d     = prog_q;
    pass_d     = pass_q;
    prog_err_d = 1'b0;
    tmr_run    = 1'b0;
    tmr_clear  = 1'b0;
    tmr_target = TW'(cfg.wash_ticks);
    case (state_q)
      S_IDLE: begin
        if (prog_load) begin
          if (prog_e'(prog_sel) == PROG_RSVD) begin
            prog_err_d = 1'b1;
          end else begin
            prog_d  = prog_e'(prog_sel);
            state_d = S_ARMED;
          end
        end
      end
      S_ARMED: begin
        if (water_wash) begin
          tmr_clear = 1'b1;
          tmr_run   = 1'b1;
          state_d   = S_WASH;
        end
      end
      S_WASH: begin
        if (water_wash) begin
          tmr_run = 1'b1;
        end else begin
          state_d = S_POST_WASH;
          if (pass_q < cfg.passes) begin
            pass_d = pass_q + 1'b1;
          end
        end
      end
      S_POST_WASH: begin
        if (water_wash) begin
          tmr_clear = 1'b1;
          tmr_run   = 1'b1;
          state_d   = S_WASH;
        end else if (spin_phase) begin
          tmr_clear  = 1'b1;
          tmr_run    = 1'b1;
          tmr_target = TW'(cfg.spin_ticks);
          state_d    = S_SPIN;
        end
      end
      S_SPIN: begin
        tmr_target = TW'(cfg.spin_ticks);
        tmr_run    = spin_phase;
        if (done) begin
          state_d = S_IDLE;
          pass_d  = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        pass_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      prog_q     <= PROG_NORMAL;
      pass_q     <= '0;
      prog_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      prog_q     <= prog_d;
      pass_q     <= pass_d;
      prog_err_q <= prog_err_d;
    end
  end

  phase_timer #(
    .TICK_DIV (TICK_DIV),
    .TW       (TW)
  ) u_timer (
    .clk       (clk),
    .reset_n   (reset_n),
    .run_i     (tmr_run),
    .clear_i   (tmr_clear),
    .target_i  (tmr_target),
    .expired_o (tmr_expired)
  );

  // Timeouts come from the registered tick count and state only.
  assign cycleTO   = (state_q == S_WASH) & tmr_expired;
  assign spinTO    = (state_q == S_SPIN) & tmr_expired;
  assign againwash = (state_q == S_POST_WASH) & (pass_q < cfg.passes);
  assign busy      = (state_q != S_IDLE);
  assign pass_idx  = pass_q;
  assign prog_err  = prog_err_q;

endmodule
